// File: rtl/ifetcher_rcvbuf.sv
// Receive buffer between the instruction-memory response path and decode-issue.
// Optional fall-through when empty is enabled with IFETCHER_RCVBUF_BYPASS_EN.
module ifetcher_rcvbuf #(
  parameter int IW     = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int AF_LVL = 6
) (
  input  logic                iClk,
  input  logic                resetN,
  input  logic                iClear,
  input  logic                iWE,
  input  logic [IW*LANES-1:0] iWD,
  input  logic                iWFault,
  input  logic                iRE,
  output logic [IW*LANES-1:0] oRD,
  output logic                oRFault,
  output logic                oEmpty,
  output logic                oFull,
  output logic                oAlmostFull,
  output logic [AW:0]         oCount,
  output logic                oOverflow,
  output logic                oUnderflow
);

  localparam int DW = IW * LANES;
  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LVL);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] fault_q;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic ptr_empty, ptr_full, bypass, wr_acc, rd_acc;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign ptr_empty = (wptr_q == rptr_q);
  assign ptr_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

`ifdef IFETCHER_RCVBUF_BYPASS_EN
  assign bypass = ptr_empty && iWE && !iClear;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    wr_acc = iWE && !ptr_full && !iClear && !(bypass && iRE);
    rd_acc = iRE && !ptr_empty && !iClear;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (iClear) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_acc)
        wptr_d = wptr_q + ONE;
      if (rd_acc)
        rptr_d = rptr_q + ONE;
      if (iWE && ptr_full)
        ovf_d = 1'b1;
      if (iRE && ptr_empty && !bypass)
        udf_d = 1'b1;
    end
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge iClk or negedge resetN) begin
    if (!resetN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Line storage is deliberately left unreset; empty masks stale contents.
  always_ff @(posedge iClk) begin
    if (wr_acc) begin
      mem_q[wptr_q[AW-1:0]]   <= iWD;
      fault_q[wptr_q[AW-1:0]] <= iWFault;
    end
  end

  assign oRD         = bypass ? iWD : mem_q[rptr_q[AW-1:0]];
  assign oRFault     = bypass ? iWFault : fault_q[rptr_q[AW-1:0]];
  assign oEmpty      = ptr_empty && !bypass;
  assign oFull       = ptr_full;
  assign oAlmostFull = (count_q >= AF_THR);
  assign oCount      = count_q;
  assign oOverflow   = ovf_q;
  assign oUnderflow  = udf_q;

endmodule

// File: tb/tb_ifetcher_rcvbuf.sv
// Self-checking bench for ifetcher_rcvbuf against a queue-based reference model.
// Follows IFETCHER_RCVBUF_BYPASS_EN when it is defined for the build.
module tb_ifetcher_rcvbuf;

  localparam int DEPTH  = 8;
  localparam int AF_LVL = 6;
  localparam int DW     = 128;
`ifdef IFETCHER_RCVBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          iClk = 1'b0;
  logic          resetN;
  logic          iClear;
  logic          iWE;
  logic [DW-1:0] iWD;
  logic          iWFault;
  logic          iRE;
  logic [DW-1:0] oRD;
  logic          oRFault, oEmpty, oFull, oAlmostFull, oOverflow, oUnderflow;
  logic [3:0]    oCount;

  ifetcher_rcvbuf dut (
    .iClk(iClk), .resetN(resetN), .iClear(iClear), .iWE(iWE), .iWD(iWD),
    .iWFault(iWFault), .iRE(iRE), .oRD(oRD), .oRFault(oRFault), .oEmpty(oEmpty),
    .oFull(oFull), .oAlmostFull(oAlmostFull), .oCount(oCount),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 iClk = ~iClk;

  logic [DW:0] q[$];
  bit          mOvf, mUdf;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare every visible output with what the model says right now.
  task automatic checkOutput(input string tag);
    bit          byp;
    bit          expEmpty;
    logic [DW:0] head;
    byp      = BYP && iWE && !iClear && (q.size() == 0);
    expEmpty = (q.size() == 0) && !byp;
    checks++;
    assert (oCount === 4'(q.size())) else begin
      errors++; $error("FAIL %s count observed=%0d expected=%0d", tag, oCount, q.size());
    end
    checks++;
    assert (oEmpty === expEmpty) else begin
      errors++; $error("FAIL %s empty observed=%b expected=%b", tag, oEmpty, expEmpty);
    end
    checks++;
    assert (oFull === (q.size() == DEPTH)) else begin
      errors++; $error("FAIL %s full observed=%b expected=%b", tag, oFull, q.size() == DEPTH);
    end
    checks++;
    assert (oAlmostFull === (q.size() >= AF_LVL)) else begin
      errors++; $error("FAIL %s afull observed=%b expected=%b", tag, oAlmostFull, q.size() >= AF_LVL);
    end
    checks++;
    assert (oOverflow === mOvf) else begin
      errors++; $error("FAIL %s overflow observed=%b expected=%b", tag, oOverflow, mOvf);
    end
    checks++;
    assert (oUnderflow === mUdf) else begin
      errors++; $error("FAIL %s underflow observed=%b expected=%b", tag, oUnderflow, mUdf);
    end
    if (!expEmpty) begin
      head = byp ? {iWFault, iWD} : q[0];
      checks++;
      assert (oRD === head[DW-1:0]) else begin
        errors++; $error("FAIL %s rdata observed=%h expected=%h", tag, oRD, head[DW-1:0]);
      end
      checks++;
      assert (oRFault === head[DW]) else begin
        errors++; $error("FAIL %s rfault observed=%b expected=%b", tag, oRFault, head[DW]);
      end
    end
  endtask

  // Reference behaviour at a clock edge, from the pre-edge occupancy.
  task automatic modelEdge(input bit we, input logic [DW-1:0] wd, input bit wf,
                           input bit re, input bit clr);
    int n;
    bit byp;
    n   = q.size();
    byp = BYP && we && !clr && (n == 0);
    if (clr) begin
      q.delete();
      mOvf = 1'b0;
      mUdf = 1'b0;
    end else if (!(byp && re)) begin
      if (re) begin
        if (n > 0) q.delete(0);
        else if (!byp) mUdf = 1'b1;
      end
      if (we) begin
        if (n < DEPTH) q.push_back({wf, wd});
        else mOvf = 1'b1;
      end
    end
  endtask

  // One directed cycle: drive after the falling edge, check, clock, model.
  task automatic applyStimulus(input bit we, input logic [DW-1:0] wd, input bit wf,
                               input bit re, input bit clr, input string tag);
    iWE = we; iWD = wd; iWFault = wf; iRE = re; iClear = clr;
    #1 checkOutput(tag);
    @(posedge iClk);
    modelEdge(we, wd, wf, re, clr);
    @(negedge iClk);
  endtask

  task automatic applyResetPulse();
    iWE = 1'b0; iRE = 1'b0; iClear = 1'b0;
    #2 resetN = 1'b0;
    q.delete(); mOvf = 1'b0; mUdf = 1'b0;
    #1 checkOutput("reset_mid");
    @(negedge iClk);
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0; iClear = 1'b0; iWE = 1'b0; iRE = 1'b0; iWD = '0; iWFault = 1'b0;
    mOvf = 1'b0; mUdf = 1'b0;
    repeat (2) @(negedge iClk);
    #1 checkOutput("reset");
    resetN = 1'b1;
    @(negedge iClk);

    for (int i = 0; i < 8; i++) applyStimulus(1, DW'(i + 1), i[0], 0, 0, "fill");
    applyStimulus(1, DW'('h99), 1, 0, 0, "ovf_write");
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0, 1, 0, "pop");
    applyStimulus(0, '0, 0, 0, 1, "clear");
    applyStimulus(0, '0, 0, 0, 0, "after_clear");

    applyStimulus(0, '0, 0, 1, 0, "underflow");
    applyStimulus(1, DW'('hA), 0, 0, 0, "write_a");
    applyStimulus(0, '0, 0, 0, 0, "hold_a");
    applyStimulus(0, '0, 0, 0, 1, "clear2");

    applyStimulus(1, DW'(0), 0, 0, 0, "wrap_first");
    for (int i = 1; i < 20; i++) applyStimulus(1, DW'(i), i[1], 1, 0, "wrap");
    applyStimulus(0, '0, 0, 1, 0, "wrap_last");

    for (int i = 0; i < 8; i++) applyStimulus(1, rnd128(), 1'($urandom), 0, 0, "fill2");
    applyStimulus(1, DW'('h55), 0, 1, 0, "full_rw");
    applyStimulus(0, '0, 0, 0, 0, "after_full_rw");
    applyStimulus(0, '0, 0, 0, 1, "clear3");

    for (int i = 0; i < 5; i++) applyStimulus(1, rnd128(), 1'($urandom), 0, 0, "fill5");
    applyStimulus(1, DW'('hEE), 1, 0, 1, "clear_with_write");
    applyStimulus(0, '0, 0, 0, 0, "after_clear_write");

    for (int i = 0; i < 5; i++) applyStimulus(1, rnd128(), 1'($urandom), 0, 0, "fill_rst");
    applyResetPulse();
    applyStimulus(0, '0, 0, 0, 0, "after_reset");

    applyStimulus(1, DW'('h77), 0, 1, 0, "empty_we_re");
    applyStimulus(0, '0, 0, 0, 0, "after_empty_we_re");
    applyStimulus(0, '0, 0, 0, 1, "clear4");

    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 9) < 6), rnd128(), 1'($urandom),
                    ($urandom_range(0, 9) < 5), ($urandom_range(0, 39) == 0), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetcher_rcvbuf.md
Name: ifetcher_rcvbuf

Overview:
Parametrised receive buffer between the instruction-memory response path and the ifetcher decode-issue stage. It holds fetched instruction lines (LANES instructions of IW bits each) with a per-line fetch-fault tag. It provides exact full/empty detection, an occupancy count, an almost-full threshold for fetch throttling, a synchronous flush for branch redirects, and sticky overflow/underflow error flags.

Parameters:
IW, 32, instruction width in bits
LANES, 4, instructions per buffered line; data width is IW*LANES
DEPTH, 8, number of entries; must be a power of 2, at least 2
AW, 3, log2(DEPTH); pointer index width
AF_LVL, 6, oAlmostFull asserts when occupancy >= AF_LVL; range 1..DEPTH

Ports:
iClk  in  1  clock, rising edge
resetN  in  1  reset, asynchronous, active-low
iClear  in  1  synchronous flush (redirect)
iWE  in  1  write request
iWD  in  IW*LANES  write line
iWFault  in  1  fetch fault tag for the written line
iRE  in  1  read (pop) request
oRD  out  IW*LANES  head line data
oRFault  out  1  head line fault tag
oEmpty  out  1  buffer empty
oFull  out  1  buffer full
oAlmostFull  out  1  occupancy >= AF_LVL
oCount  out  AW+1  occupancy, 0..DEPTH
oOverflow  out  1  sticky: write attempted while full
oUnderflow  out  1  sticky: read attempted while empty

Behaviour:
- Clock iClk; reset resetN, asynchronous, active-low.
- Reset values: read/write pointers 0, oCount=0, oEmpty=1, oFull=0, oAlmostFull=0, oOverflow=0, oUnderflow=0. Storage array is not reset. oRD/oRFault are don't-care while empty.
- Pointers are AW+1 bits wide; the MSB is the wrap bit. Empty means the pointers are equal. Full means the index bits are equal and the wrap bits differ. All DEPTH entries are usable.
- Wrap-around: index is the pointer modulo DEPTH; the pointer increments naturally past 2*DEPTH-1 to 0.
- Write accept: iWE && !oFull && !iClear. The line is stored at the write index with iWFault. wptr advances by 1.
- Read accept: iRE && !oEmpty && !iClear. rptr advances by 1.
- oRD/oRFault are combinational from the entry at the read index. The head is visible in the same cycle oEmpty=0. Write-to-read latency is 1 cycle: data written at edge N is readable after edge N.
- Simultaneous accepted read and write: both pointers advance and the count is unchanged. When full, the write is rejected even if a read is accepted in the same cycle, because oFull is evaluated before the edge. When empty, the read is rejected even with a simultaneous write.
- oCount = wptr - rptr, computed mod 2^(AW+1). It is registered and updated with the pointers. oAlmostFull and oFull derive from the registered state.
- Overflow: iWE && oFull && !iClear sets oOverflow at the next edge. The write is dropped and state is unchanged.
- Underflow: iRE && oEmpty && !iClear sets oUnderflow at the next edge. The read is ignored.
- The sticky flags stay set until iClear or reset.
- iClear (synchronous): at the next edge, pointers go to 0, count goes to 0, and both sticky flags clear. Any concurrent iWE/iRE is discarded. iClear has priority over all other events.
- Reset asserted mid-operation forces reset values immediately. Buffered contents are lost.

Optional Feature:
Macro IFETCHER_RCVBUF_BYPASS_EN.
- Defined: fall-through path when the buffer is empty. If oEmpty=1 and iWE=1 and iClear=0:
  - oRD=iWD and oRFault=iWFault combinationally, and oEmpty is driven 0 in that cycle.
  - If iRE=1 in the same cycle, the line is consumed directly. It is not stored, the pointers and count are unchanged, and oUnderflow is not set.
  - If iRE=0, the line is written normally.
- Not defined: no bypass. oEmpty is purely registered state. A same-cycle read while empty is an underflow, as specified above.

Test Plan:
- Reset then fill: write lines 0x1..0x8 (tags alternating 0/1) over 8 cycles. Expected: oCount steps 1..8, oAlmostFull rises after the 6th write, oFull=1 after the 8th. Then pop 8: oRD sequence 0x1..0x8 with matching tags, oEmpty=1 at the end.
- Overflow: with the buffer full, write 0x99. Expected: oOverflow=1 next cycle, oCount stays 8, subsequent pops never return 0x99. Then pulse iClear: oOverflow=0, oCount=0, oEmpty=1.
- Underflow: with the buffer empty (no bypass macro), assert iRE=1 with iWE=0. Expected: oUnderflow=1, pointers unchanged. A following write of 0xA gives oRD=0xA and oCount=1.
- Wrap: stream 20 writes with 1-cycle-lagged concurrent reads. Expected: oCount holds at 1, output order is exactly 0..19, the pointer wraps past 15 with no data loss.
- Full with simultaneous read/write: at oCount=8, assert iWE=1 (0x55) and iRE=1. Expected: pop accepted, write rejected, oOverflow=1, oCount=7.
- Flush/reset mid-stream: at oCount=5, assert iClear with iWE=1 in the same cycle. Expected: oCount=0 and the written line is discarded. Repeat with resetN pulsed low mid-cycle: all outputs go to reset values immediately. With IFETCHER_RCVBUF_BYPASS_EN, an empty buffer with iWE=iRE=1 and data 0x77 gives oRD=0x77 in that cycle, oEmpty=0 in that cycle, and oCount stays 0.
